// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-wide memory bus of the load/store unit.
// The unit sits on the slave side; the execute stage and memory sit on the master side.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [31:0]           req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  mem_write_o;
    logic                  mem_read_o;
    logic [31:0]           mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end: alignment/range check, read-modify-write for sub-word
// stores into a word-only memory, and sign/zero extension of load data.
module load_store_unit #(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          MEMORY_DEPTH = 256
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * MEMORY_DEPTH) - 32'd1;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic                  uns;
        logic [31:0]           addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  err;
    } req_t;

    state_t                state_q, state_d;
    req_t                  req_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  accept, acc_err;
    logic [4:0]            shift;
    logic [DATA_WIDTH-1:0] shifted, lane_mask, merged, ext;

    assign accept = (state_q == IDLE) && bus.req_valid_i;

    always_comb begin
        acc_err = 1'b0;
        if (bus.req_size_i == 2'b11)                                 acc_err = 1'b1;
        if (bus.req_size_i == 2'b01 && bus.req_addr_i[0])            acc_err = 1'b1;
        if (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00) acc_err = 1'b1;
        if (bus.req_addr_i < BASE_ADDR || bus.req_addr_i > LAST_ADDR) acc_err = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                req_q <= '{we: bus.req_we_i, size: bus.req_size_i, uns: bus.req_unsigned_i,
                           addr: bus.req_addr_i, wdata: bus.req_wdata_i, err: acc_err};
            if (state_q == RD)
                word_q <= bus.mem_rdata_i;
        end
    end

    // Halfwords are known aligned here, so one byte-granular shift serves both sizes.
    assign shift     = {req_q.addr[1:0], 3'b000};
    assign shifted   = word_q >> shift;
    assign lane_mask = ((req_q.size == 2'b00) ? DATA_WIDTH'(32'hFF) : DATA_WIDTH'(32'hFFFF)) << shift;
    assign merged    = (word_q & ~lane_mask) | ((req_q.wdata << shift) & lane_mask);

    always_comb begin
        case (req_q.size)
            2'b00:   ext = req_q.uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
            2'b01:   ext = req_q.uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = word_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid_i) begin
                if (acc_err)                     state_d = RSP;
                else if (!bus.req_we_i)          state_d = RD;
                else if (bus.req_size_i == 2'b10) state_d = WR;
                else                             state_d = RD;
            end
            RD:      state_d = req_q.we ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state_q == IDLE);
        bus.mem_read_o  = (state_q == RD);
        bus.mem_write_o = (state_q == WR);
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.rsp_valid_o = (state_q == RSP);
        bus.rsp_err_o   = (state_q == RSP) && req_q.err;
        bus.rsp_rdata_o = '0;
        if (state_q == RD || state_q == WR)
            bus.mem_addr_o = {req_q.addr[31:2], 2'b00};
        if (state_q == WR)
            bus.mem_wdata_o = (req_q.size == 2'b10) ? req_q.wdata : merged;
        if (state_q == RSP && !req_q.we && !req_q.err)
            bus.rsp_rdata_o = ext;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word behavioural data memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cmp = 0;
    int   mis = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] mem [0:255] = '{default: 32'h0};
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32)) bus ();

    load_store_unit #(.DATA_WIDTH(32), .BASE_ADDR(32'h10010000), .MEMORY_DEPTH(256)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (bus.mem_read_o) rd_cnt++;
        if (bus.mem_write_o) begin
            wr_cnt++;
            last_wdata = bus.mem_wdata_o;
            mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Drives one request, waits for its response and completes the handshake.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rds, output int wrs);
        int r0, w0, i;
        rdata = '0; err = 1'b0; lat = 0; rds = 0; wrs = 0;
        @(negedge clk);
        r0 = rd_cnt; w0 = wr_cnt;
        bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = size;
        bus.req_unsigned_i = uns; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
        i = 0;
        while (!bus.req_ready_o && i < 20) begin @(negedge clk); i++; end
        if (!bus.req_ready_o) begin
            cmp++; mis++;
            $display("FAIL accept_timeout addr=%h got ready=0 want 1", addr);
            bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        while (!bus.rsp_valid_o && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        if (!bus.rsp_valid_o) begin
            cmp++; mis++;
            $display("FAIL rsp_timeout addr=%h got valid=0 want 1", addr);
            return;
        end
        rdata = bus.rsp_rdata_o; err = bus.rsp_err_o;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        rds = rd_cnt - r0; wrs = wr_cnt - w0;
    endtask

    task automatic test_reset();
        #12;
        cmp += 8;
        if (bus.req_ready_o !== 1'b1) begin mis++; $display("FAIL rst_ready got %b want 1", bus.req_ready_o); end
        if (bus.rsp_valid_o !== 1'b0) begin mis++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid_o); end
        if (bus.rsp_err_o !== 1'b0) begin mis++; $display("FAIL rst_err got %b want 0", bus.rsp_err_o); end
        if (bus.rsp_rdata_o !== 32'h0) begin mis++; $display("FAIL rst_rdata got %h want 0", bus.rsp_rdata_o); end
        if (bus.mem_read_o !== 1'b0) begin mis++; $display("FAIL rst_mem_read got %b want 0", bus.mem_read_o); end
        if (bus.mem_write_o !== 1'b0) begin mis++; $display("FAIL rst_mem_write got %b want 0", bus.mem_write_o); end
        if (bus.mem_addr_o !== 32'h0) begin mis++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr_o); end
        if (bus.mem_wdata_o !== 32'h0) begin mis++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata_o); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd; logic er; int lat, rds, wrs;
        xact(1'b1, 2'b10, 1'b0, 32'h10010008, 32'hDEADBEEF, rd, er, lat, rds, wrs);
        cmp += 5;
        if (er !== 1'b0) begin mis++; $display("FAIL sw_err got %b want 0", er); end
        if (rd !== 32'h0) begin mis++; $display("FAIL sw_rdata got %h want 0", rd); end
        if (wrs != 1) begin mis++; $display("FAIL sw_write_pulses got %0d want 1", wrs); end
        if (lat != 2) begin mis++; $display("FAIL sw_latency got %0d want 2", lat); end
        if (mem[2] !== 32'hDEADBEEF) begin mis++; $display("FAIL sw_mem got %h want deadbeef", mem[2]); end
        xact(1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, rd, er, lat, rds, wrs);
        cmp += 5;
        if (rd !== 32'hDEADBEEF) begin mis++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        if (er !== 1'b0) begin mis++; $display("FAIL lw_err got %b want 0", er); end
        if (lat != 2) begin mis++; $display("FAIL lw_latency got %0d want 2", lat); end
        if (rds != 1) begin mis++; $display("FAIL lw_read_pulses got %0d want 1", rds); end
        if (wrs != 0) begin mis++; $display("FAIL lw_write_pulses got %0d want 0", wrs); end
    endtask

    task automatic test_subword_merge();
        logic [31:0] rd; logic er; int lat, rds, wrs;
        preload(8'd0, 32'h11223344);
        xact(1'b1, 2'b00, 1'b0, 32'h10010002, 32'h000000AA, rd, er, lat, rds, wrs);
        cmp += 5;
        if (last_wdata !== 32'h11AA3344) begin mis++; $display("FAIL sb_merge got %h want 11aa3344", last_wdata); end
        if (rds != 1) begin mis++; $display("FAIL sb_read_pulses got %0d want 1", rds); end
        if (wrs != 1) begin mis++; $display("FAIL sb_write_pulses got %0d want 1", wrs); end
        if (lat != 3) begin mis++; $display("FAIL sb_latency got %0d want 3", lat); end
        if (er !== 1'b0) begin mis++; $display("FAIL sb_err got %b want 0", er); end
        xact(1'b1, 2'b01, 1'b0, 32'h10010000, 32'h1234BEEF, rd, er, lat, rds, wrs);
        cmp += 2;
        if (mem[0] !== 32'h11AABEEF) begin mis++; $display("FAIL sh_merge got %h want 11aabeef", mem[0]); end
        if (wrs != 1) begin mis++; $display("FAIL sh_write_pulses got %0d want 1", wrs); end
    endtask

    task automatic test_extension();
        logic [31:0] addrs [5] = '{32'h10010005, 32'h10010006, 32'h10010007, 32'h10010006, 32'h10010006};
        logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        unss  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        logic [31:0] rd; logic er; int lat, rds, wrs;
        preload(8'd1, 32'h80FF7F01);
        for (int k = 0; k < 5; k++) begin
            xact(1'b0, sizes[k], unss[k], addrs[k], 32'h0, rd, er, lat, rds, wrs);
            cmp += 2;
            if (rd !== exps[k]) begin mis++; $display("FAIL ext_rdata[%0d] got %h want %h", k, rd, exps[k]); end
            if (er !== 1'b0) begin mis++; $display("FAIL ext_err[%0d] got %b want 0", k, er); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5] = '{32'h10010002, 32'h10010001, 32'h10010000, 32'h1000FFFC, 32'h10010400};
        logic [1:0]  sizes [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
        logic        wes   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] rd; logic er; int lat, rds, wrs;
        for (int k = 0; k < 5; k++) begin
            xact(wes[k], sizes[k], 1'b0, addrs[k], 32'hFFFFFFFF, rd, er, lat, rds, wrs);
            cmp += 4;
            if (er !== 1'b1) begin mis++; $display("FAIL err_flag[%0d] got %b want 1", k, er); end
            if (rd !== 32'h0) begin mis++; $display("FAIL err_rdata[%0d] got %h want 0", k, rd); end
            if (rds + wrs != 0) begin mis++; $display("FAIL err_mem_pulses[%0d] got %0d want 0", k, rds + wrs); end
            if (lat != 1) begin mis++; $display("FAIL err_latency[%0d] got %0d want 1", k, lat); end
        end
    endtask

    task automatic test_backpressure();
        int i;
        preload(8'd3, 32'hCAFEF00D);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h1001000C; bus.req_wdata_i = '0;
        @(posedge clk);
        @(negedge clk);
        // second request shows up while the first is in flight
        bus.req_addr_i = 32'h10010008;
        i = 0;
        while (!bus.rsp_valid_o && i < 10) begin @(negedge clk); i++; end
        for (int c = 0; c < 5; c++) begin
            cmp += 3;
            if (bus.rsp_valid_o !== 1'b1) begin mis++; $display("FAIL bp_valid[%0d] got %b want 1", c, bus.rsp_valid_o); end
            if (bus.rsp_rdata_o !== 32'hCAFEF00D) begin mis++; $display("FAIL bp_rdata[%0d] got %h want cafef00d", c, bus.rsp_rdata_o); end
            if (bus.req_ready_o !== 1'b0) begin mis++; $display("FAIL bp_ready[%0d] got %b want 0", c, bus.req_ready_o); end
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        cmp += 2;
        if (bus.mem_read_o !== 1'b0) begin mis++; $display("FAIL bp_early_accept got read=%b want 0", bus.mem_read_o); end
        if (bus.req_ready_o !== 1'b1) begin mis++; $display("FAIL bp_idle_ready got %b want 1", bus.req_ready_o); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        cmp += 2;
        if (bus.mem_read_o !== 1'b1) begin mis++; $display("FAIL bp_second_read got %b want 1", bus.mem_read_o); end
        if (bus.mem_addr_o !== 32'h10010008) begin mis++; $display("FAIL bp_second_addr got %h want 10010008", bus.mem_addr_o); end
        i = 0;
        while (!bus.rsp_valid_o && i < 10) begin @(negedge clk); i++; end
        cmp++;
        if (bus.rsp_rdata_o !== 32'hDEADBEEF) begin mis++; $display("FAIL bp_second_rdata got %h want deadbeef", bus.rsp_rdata_o); end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        int w0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h10010004; bus.req_wdata_i = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        cmp++;
        if (bus.mem_write_o !== 1'b1) begin mis++; $display("FAIL rms_in_wr got write=%b want 1", bus.mem_write_o); end
        w0 = wr_cnt;
        reset = 1'b1;
        #1;
        cmp += 3;
        if (bus.req_ready_o !== 1'b1) begin mis++; $display("FAIL rms_ready got %b want 1", bus.req_ready_o); end
        if (bus.rsp_valid_o !== 1'b0) begin mis++; $display("FAIL rms_rsp_valid got %b want 0", bus.rsp_valid_o); end
        if (bus.mem_write_o !== 1'b0) begin mis++; $display("FAIL rms_write got %b want 0", bus.mem_write_o); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp += 2;
        if (wr_cnt != w0) begin mis++; $display("FAIL rms_write_pulses got %0d want %0d", wr_cnt, w0); end
        if (mem[1] !== 32'h80FF7F01) begin mis++; $display("FAIL rms_mem got %h want 80ff7f01", mem[1]); end
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        test_reset();
        test_word_store_load();
        test_subword_merge();
        test_extension();
        test_errors();
        test_backpressure();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential front end between the execute stage and the word-wide data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Checks alignment and address range, and performs read-modify-write for sub-word stores, since the memory writes whole words only.
- Extracts and sign- or zero-extends load data, then returns one response per request.

Parameters:
DATA_WIDTH, 32, datapath width (only 32 supported)
BASE_ADDR, 32'h10010000, first byte address of data memory
MEMORY_DEPTH, 256, memory size in words; valid range is BASE_ADDR to BASE_ADDR+4*MEMORY_DEPTH-1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  unit can accept a request
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  zero-extend load (lbu/lhu)
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-justified
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  consumer takes response
rsp_rdata_o  output  32  extended load data; 0 for stores and errors
rsp_err_o  output  1  misaligned, illegal size or out-of-range access
mem_write_o  output  1  data memory write enable
mem_read_o  output  1  data memory read enable
mem_addr_o  output  32  word-aligned byte address {addr[31:2],2'b00}
mem_wdata_o  output  32  word to write
mem_rdata_i  input  32  combinational read data from memory

Behaviour:
- States: IDLE, RD, WR, RSP.
- Reset (async, any state) forces IDLE and clears all latched request fields and the captured word.
  - Outputs after reset: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-operation aborts the request: no memory write occurs on or after the edge where reset is sampled, and any pending response is discarded.
- req_ready_o=1 only in IDLE.
  - Handshake occurs when req_valid_i and req_ready_o are both 1 at a rising edge. The request fields are latched at that edge.
- Error check at accept, with any of the following conditions giving an error:
  - size=11;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]!=0;
  - addr<BASE_ADDR or addr>BASE_ADDR+4*MEMORY_DEPTH-1 (32-bit unsigned compare).
  - On error, go to RSP with err=1 and rdata=0. No mem_read_o or mem_write_o pulse is issued.
- Load: IDLE -> RD -> RSP.
  - In RD: mem_read_o=1 and mem_addr_o=aligned address.
  - The word is captured from mem_rdata_i at the end of RD.
  - rsp_valid_o rises 2 cycles after the accept edge.
- Word store: IDLE -> WR -> RSP.
  - In WR: mem_write_o=1 and mem_wdata_o=req_wdata_i; the write completes on the WR->RSP edge.
- Byte/half store: IDLE -> RD -> WR -> RSP.
  - The old word is read in RD.
  - In WR, the merged word is written. Byte lane addr[1:0] (or half lane addr[1]) is replaced by wdata[7:0] (or wdata[15:0]); all other bits are kept.
- Load extraction:
  - Byte: lane = word >> (8*addr[1:0]).
  - Half: lane = word >> (16*addr[1]).
  - Extension: sign-extend from bit 7 or bit 15 unless req_unsigned_i=1, in which case zero-extend. Words pass through unchanged.
- mem_read_o and mem_write_o are never both 1. Both are 0 outside RD and WR respectively.
- mem_addr_o and mem_wdata_o are 0 in IDLE and RSP.
- RSP:
  - rsp_valid_o=1 and outputs are stable until rsp_ready_i=1 at an edge, then the state returns to IDLE.
  - No new request is accepted in the cycle of the response handshake; the next accept is possible one cycle later.
  - Store responses: rdata=0, err=0.
- req_valid_i outside IDLE is ignored. The upstream stage holds the request until it is accepted.

Test Plan:
- Reset mid-store: reset high during the WR cycle of sb 0x10010004 -> no memory write; req_ready_o=1 and rsp_valid_o=0 immediately; memory word unchanged.
- Word store then load: sw 0xDEADBEEF to 0x10010008, then lw 0x10010008 -> store response err=0; load rsp_rdata_o=0xDEADBEEF arrives 2 cycles after accept; the store shows exactly one mem_write_o pulse.
- Sub-word merge: word 0x11223344 at 0x10010000; sb 0xAA at 0x10010002 -> RD then WR with mem_wdata_o=0x11AA3344. Then sh 0xBEEF at 0x10010000 -> word becomes 0x11AABEEF.
- Extension: word 0x80FF7F01. lb at +1 -> 0x0000007F; lb at +2 -> 0xFFFFFFFF; lbu at +3 -> 0x00000080; lh at +2 -> 0xFFFF80FF; lhu at +2 -> 0x000080FF.
- Errors: lw 0x10010002, lh 0x10010001, size=11, lw 0x1000FFFC, sw 0x10010400 -> each gives rsp_err_o=1, rdata=0, and no mem_read_o or mem_write_o pulse; response arrives 1 cycle after accept.
- Backpressure: hold rsp_ready_i=0 for 5 cycles after an lw -> rsp_valid_o and rsp_rdata_o stay stable, req_ready_o=0; a new request arriving meanwhile is accepted only after the response handshake.
